// File: rtl/spi_load_sequencer.sv
// spi_load_sequencer: turns the SPI programming byte stream into word writes
// for imem/dmem while the core is held in reset.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   rx_byte       - byte from the SPI slave receiver
//   rx_valid      - rx_byte is valid; taken when rx_valid && rx_ready
//   rx_ready      - sequencer can take a byte (low only while writing)
//   frame_abort   - chip-select deasserted; drops a partial frame
//   mem_we        - write request, held until mem_ready
//   mem_addr      - word-aligned byte address (always shows addr_reg)
//   mem_wdata     - write data
//   mem_ready     - memory accepts the write
//   busy          - sequencer is not idle
//   err_opcode    - one-cycle pulse after an unknown opcode byte
//   err_range     - one-cycle pulse after a write is dropped
//   wr_count      - completed writes, saturating
//
// Frames: 0x01 + 4 address bytes, 0x02 + 4 data bytes (MSB first).
// Each data frame writes to the current address, then the address steps by 4.

module spi_load_sequencer #(
   parameter logic [31:0] LOAD_BASE  = 32'h1000_0000,
   parameter logic [31:0] LOAD_LIMIT = 32'h1000_8000,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_byte,
   input  logic             rx_valid,
   output logic             rx_ready,
   input  logic             frame_abort,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ready,
   output logic             busy,
   output logic             err_opcode,
   output logic             err_range,
   output logic [CNT_W-1:0] wr_count
);

   localparam logic [7:0] OP_ADDR = 8'h01;
   localparam logic [7:0] OP_DATA = 8'h02;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_WRITE
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [31:0]       addr_q;
   logic [31:0]       shadow_q;
   logic [31:0]       data_q;
   logic [1:0]        byte_cnt_q;
   logic [CNT_W-1:0]  wr_count_q;
   logic              err_opcode_q;
   logic              err_range_q;

   logic              accept;
   logic              last_byte;
   logic              addr_legal;
   logic              is_op_addr;
   logic              is_op_data;
   logic              write_done;
   logic [31:0]       shadow_next;
   logic [31:0]       data_next;

   assign accept      = rx_valid && rx_ready;
   assign last_byte   = (byte_cnt_q == 2'd3);
   assign is_op_addr  = (rx_byte == OP_ADDR);
   assign is_op_data  = (rx_byte == OP_DATA);
   assign shadow_next = {shadow_q[23:0], rx_byte};
   assign data_next   = {data_q[23:0], rx_byte};

   // The write window is [LOAD_BASE, LOAD_LIMIT) and must be word aligned.
   assign addr_legal = (addr_q >= LOAD_BASE)
                    && (addr_q <  LOAD_LIMIT)
                    && (addr_q[1:0] == 2'b00);

   assign write_done = (state_q == S_WRITE) && addr_legal && mem_ready;

   // ------------------------------------------------------------
   // State register
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------
   // Next state and handshake outputs
   // ------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rx_ready = 1'b1;
      mem_we   = 1'b0;
      busy     = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            // frame_abort has no meaning here; the byte is still taken
            if (accept) begin
               if (is_op_addr) begin
                  state_d = S_ADDR;
               end else if (is_op_data) begin
                  state_d = S_DATA;
               end
            end
         end

         S_ADDR: begin
            // abort beats a coincident byte
            if (frame_abort) begin
               state_d = S_IDLE;
            end else if (accept && last_byte) begin
               state_d = S_IDLE;
            end
         end

         S_DATA: begin
            if (frame_abort) begin
               state_d = S_IDLE;
            end else if (accept && last_byte) begin
               state_d = S_WRITE;
            end
         end

         S_WRITE: begin
            // abort is ignored: a raised mem_we waits for mem_ready
            rx_ready = 1'b0;
            if (addr_legal) begin
               mem_we = 1'b1;
               if (mem_ready) begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Datapath: shift registers, address, counters, error pulses
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q       <= LOAD_BASE;
         shadow_q     <= 32'h0;
         data_q       <= 32'h0;
         byte_cnt_q   <= 2'd0;
         wr_count_q   <= '0;
         err_opcode_q <= 1'b0;
         err_range_q  <= 1'b0;
      end else begin
         err_opcode_q <= (state_q == S_IDLE) && accept
                      && !is_op_addr && !is_op_data;
         err_range_q  <= (state_q == S_WRITE) && !addr_legal;

         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  byte_cnt_q <= 2'd0;
               end
            end

            S_ADDR: begin
               if (!frame_abort && accept) begin
                  shadow_q   <= shadow_next;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (last_byte) begin
                     addr_q <= shadow_next;
                  end
               end
            end

            S_DATA: begin
               if (!frame_abort && accept) begin
                  data_q     <= data_next;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
               end
            end

            S_WRITE: begin
               if (write_done) begin
                  addr_q <= addr_q + 32'd4;
                  if (wr_count_q != {CNT_W{1'b1}}) begin
                     wr_count_q <= wr_count_q + 1'b1;
                  end
               end
            end

            default: begin
               byte_cnt_q <= 2'd0;
            end
         endcase
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = data_q;
   assign err_opcode = err_opcode_q;
   assign err_range  = err_range_q;
   assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_spi_load_sequencer.sv
// tb_spi_load_sequencer: random and directed byte streams against a
// frame-level reference model; a monitor scores every memory write.

module tb_spi_load_sequencer;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam logic [31:0] LIMIT = 32'h1000_8000;
   localparam int          CW    = 3;
   localparam int          CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rx_byte = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic          frame_abort = 1'b0;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ready = 1'b0;
   logic          busy;
   logic          err_opcode;
   logic          err_range;
   logic [CW-1:0] wr_count;

   always #5 clk = ~clk;

   spi_load_sequencer #(
      .LOAD_BASE (BASE),
      .LOAD_LIMIT(LIMIT),
      .CNT_W     (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_abort(frame_abort),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .busy       (busy),
      .err_opcode (err_opcode),
      .err_range  (err_range),
      .wr_count   (wr_count)
   );

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         expq[$];
   logic [31:0] m_addr = BASE;
   int          m_cnt = 0;
   int          m_phase = 0;
   int          m_nb = 0;
   logic [31:0] m_acc = 32'h0;
   int          exp_eop = 0;
   int          exp_erng = 0;
   int          got_eop = 0;
   int          got_erng = 0;
   int          rdy_mode = 0;
   int          gap_max = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit legal(logic [31:0] a);
      return (a >= BASE) && (a < LIMIT) && ((a & 32'd3) == 32'd0);
   endfunction

   function automatic logic [31:0] exp_count();
      return 32'((m_cnt > CMAX) ? CMAX : m_cnt);
   endfunction

   // Frame-level reference: phase 0 = waiting for opcode,
   // 1 = collecting address, 2 = collecting data.
   task automatic model_byte(logic [7:0] b);
      if (m_phase == 0) begin
         if (b == 8'h01) begin
            m_phase = 1;
            m_nb    = 0;
         end else if (b == 8'h02) begin
            m_phase = 2;
            m_nb    = 0;
         end else begin
            exp_eop++;
         end
      end else begin
         m_acc = {m_acc[23:0], b};
         m_nb++;
         if (m_nb == 4) begin
            if (m_phase == 1) begin
               m_addr = m_acc;
            end else if (legal(m_addr)) begin
               expq.push_back('{a: m_addr, d: m_acc});
               m_addr = m_addr + 32'd4;
               m_cnt++;
            end else begin
               exp_erng++;
            end
            m_phase = 0;
         end
      end
   endtask

   // mem_ready behaviour: 0 always ready, 1 random,
   // 2 five stall cycles per write, 3 never ready
   initial begin
      int st;
      st = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = 1'($urandom_range(0, 1));
            2: begin
               if (mem_we) begin
                  if (st < 5) begin
                     mem_ready = 1'b0;
                     st++;
                  end else begin
                     mem_ready = 1'b1;
                     st = 0;
                  end
               end else begin
                  mem_ready = 1'b0;
                  st = 0;
               end
            end
            default: mem_ready = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard
   logic [31:0] pa;
   logic [31:0] pd;
   bit          stall_prev = 0;
   int          stall_n = 0;

   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 0;
         stall_n    = 0;
      end else begin
         if (stall_prev) begin
            chk("stall_we", 32'(mem_we), 32'd1);
            chk("stall_addr", mem_addr, pa);
            chk("stall_data", mem_wdata, pd);
         end
         if (err_opcode) got_eop++;
         if (err_range) got_erng++;
         if (mem_we) begin
            chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
            if (mem_ready) begin
               if (expq.size() == 0) begin
                  nchk++;
                  nerr++;
                  $display("FAIL unexpected_write: addr %h data %h, none expected",
                           mem_addr, mem_wdata);
               end else begin
                  wr_t e;
                  e = expq.pop_front();
                  chk("wr_addr", mem_addr, e.a);
                  chk("wr_data", mem_wdata, e.d);
               end
               if (rdy_mode == 2) chk("stall_len", 32'(stall_n), 32'd5);
               stall_n    = 0;
               stall_prev = 0;
            end else begin
               stall_prev = 1;
               pa         = mem_addr;
               pd         = mem_wdata;
               stall_n++;
            end
         end else begin
            stall_prev = 0;
         end
      end
   end

   task automatic idle_gap();
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(logic [7:0] b, bit ab = 0);
      int t;
      bit done;
      t           = 0;
      done        = 0;
      rx_byte     = b;
      rx_valid    = 1'b1;
      frame_abort = ab;
      while (!done) begin
         @(negedge clk);
         if (rx_ready) begin
            done = 1;
            if (ab && m_phase != 0) m_phase = 0;
            else model_byte(b);
         end else if (++t > 200) begin
            nchk++;
            nerr++;
            $display("FAIL byte_timeout: rx_ready %b expected 1", rx_ready);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      rx_valid    = 1'b0;
      frame_abort = 1'b0;
      idle_gap();
   endtask

   task automatic frame(logic [7:0] op, logic [31:0] w);
      send_byte(op);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic abort_only();
      frame_abort = 1'b1;
      @(posedge clk);
      #1;
      frame_abort = 1'b0;
      m_phase     = 0;
   endtask

   task automatic wait_idle(string nm);
      int t;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (!busy && expq.size() == 0) break;
         if (++t > 300) begin
            nchk++;
            nerr++;
            $display("FAIL %s_drain: busy %b pending %0d expected idle",
                     nm, busy, expq.size());
            break;
         end
      end
      chk({nm, "_wr_count"}, 32'(wr_count), exp_count());
      chk({nm, "_addr"}, mem_addr, m_addr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      chk("rst_addr", mem_addr, BASE);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_err_opcode", 32'(err_opcode), 32'd0);
      chk("rst_err_range", 32'(err_range), 32'd0);
      @(posedge clk);
      #1;

      // basic address + data frame
      rdy_mode = 0;
      frame(8'h01, 32'h1000_0000);
      frame(8'h02, 32'hDEAD_BEEF);
      wait_idle("t1");

      // backpressure and auto-increment
      rdy_mode = 2;
      frame(8'h01, 32'h1000_4000);
      repeat (3) frame(8'h02, $urandom);
      wait_idle("t2");

      // range / alignment errors and legal edges
      rdy_mode = 0;
      frame(8'h01, 32'h1000_8000);
      frame(8'h02, $urandom);
      frame(8'h01, 32'h0FFF_FFFC);
      frame(8'h02, $urandom);
      frame(8'h01, 32'h1000_0002);
      frame(8'h02, $urandom);
      frame(8'h01, 32'h1000_7FFC);
      frame(8'h02, 32'h0BAD_CAFE);
      frame(8'h02, 32'h1234_5678);
      wait_idle("t3");
      chk("t3_err_range", 32'(got_erng), 32'(exp_erng));

      // unknown opcode then normal frame
      send_byte(8'h55);
      frame(8'h01, 32'h1000_0100);
      wait_idle("t4");
      chk("t4_err_opcode", 32'(got_eop), 32'(exp_eop));

      // abort in address frame, then abort coincident with a data byte
      send_byte(8'h01);
      send_byte(8'h20);
      send_byte(8'h00);
      abort_only();
      @(negedge clk);
      chk("t5_busy_after_abort", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("t5_addr_kept", mem_addr, m_addr);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33, 1'b1);
      chk("t5_busy_after_abort2", 32'(busy), 32'd0);
      wait_idle("t5");

      // randomized traffic
      rdy_mode = 1;
      gap_max  = 2;
      frame(8'h01, BASE + 32'($urandom_range(0, 8191)) * 32'd4);
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            send_byte(8'($urandom_range(3, 255)));
         end else if (r <= 2) begin
            if ($urandom_range(0, 3) == 0)
               frame(8'h01, $urandom);
            else
               frame(8'h01, LIMIT - 32'd4 * 32'($urandom_range(1, 6)));
         end else if (r == 3) begin
            int k;
            k = $urandom_range(0, 3);
            send_byte($urandom_range(0, 1) ? 8'h01 : 8'h02);
            repeat (k) send_byte(8'($urandom));
            abort_only();
         end else begin
            frame(8'h02, $urandom);
         end
      end
      wait_idle("t6");
      gap_max = 0;
      chk("t6_err_range", 32'(got_erng), 32'(exp_erng));
      chk("t6_err_opcode", 32'(got_eop), 32'(exp_eop));

      // reset while a write is stalled
      rdy_mode = 3;
      frame(8'h01, 32'h1000_2000);
      frame(8'h02, 32'h1234_5678);
      begin
         int t;
         t = 0;
         while (1) begin
            @(negedge clk);
            if (mem_we) break;
            if (++t > 50) begin
               nchk++;
               nerr++;
               $display("FAIL t7_we_timeout: mem_we %b expected 1", mem_we);
               break;
            end
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      expq.delete();
      m_addr  = BASE;
      m_cnt   = 0;
      m_phase = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t7_mem_we", 32'(mem_we), 32'd0);
      chk("t7_wr_count", 32'(wr_count), 32'd0);
      chk("t7_addr", mem_addr, BASE);
      chk("t7_rx_ready", 32'(rx_ready), 32'd1);
      chk("t7_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rdy_mode = 0;
      frame(8'h02, 32'hCAFE_F00D);
      wait_idle("t7b");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/spi_load_sequencer.md
Name: spi_load_sequencer

Overview:
- Converts the SPI flash-programming byte stream into word writes for on-chip instruction/data memory while the core is held in reset.
- Sits between the SPI slave byte receiver and the imem/dmem write port inside mpw_top.
- Parses two frame types: 0x01 followed by 4 address bytes, and 0x02 followed by 4 data bytes.
- Range-checks each write, handshakes it to memory, then auto-increments the address.

Parameters:
- LOAD_BASE, 32'h1000_0000, lowest writable byte address; also the reset value of the address register.
- LOAD_LIMIT, 32'h1000_8000, exclusive upper bound of writable addresses (covers imem 0x1000_0000 and dmem 0x1000_4000).
- CNT_W, 16, width of the write counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_byte  in  8  byte from the SPI slave
- rx_valid  in  1  rx_byte valid; a byte is accepted when rx_valid && rx_ready
- rx_ready  out  1  sequencer can accept a byte
- frame_abort  in  1  one-cycle pulse when chip-select deasserts
- mem_we  out  1  write request valid
- mem_addr  out  32  write byte address, word-aligned
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready
- busy  out  1  high in any state other than IDLE
- err_opcode  out  1  one-cycle pulse on an unknown opcode
- err_range  out  1  one-cycle pulse when a write is dropped as out-of-range or misaligned
- wr_count  out  CNT_W  number of completed writes; saturates at all-ones

Behaviour:
- Reset:
  - State = IDLE; addr_reg = LOAD_BASE; shift and byte counters = 0.
  - mem_we = 0, mem_wdata = 0, err_* = 0, wr_count = 0, busy = 0, rx_ready = 1.
  - A reset asserted mid-frame or mid-write discards the operation immediately; no write completes afterwards.
- State IDLE (rx_ready = 1), on an accepted byte:
  - 0x01 → ADDR, byte counter = 0.
  - 0x02 → DATA, byte counter = 0.
  - Any other value → stay in IDLE, pulse err_opcode the next cycle.
- State ADDR (rx_ready = 1):
  - Shift accepted bytes MSB-first into a shadow register.
  - On the 4th byte: copy shadow to addr_reg and return to IDLE. addr_reg is updated the cycle after the 4th byte is accepted.
- State DATA (rx_ready = 1):
  - Shift accepted bytes MSB-first into the data register.
  - On the 4th byte → WRITE.
- State WRITE (rx_ready = 0):
  - Legal address (LOAD_BASE <= addr_reg < LOAD_LIMIT and addr_reg[1:0] == 0):
    - mem_we = 1, with mem_addr = addr_reg and mem_wdata held stable until mem_ready.
    - On handshake: addr_reg += 4 (32-bit wrap), wr_count += 1 unless saturated, next state IDLE.
  - Illegal address: no mem_we; pulse err_range; addr_reg unchanged; wr_count unchanged; → IDLE in one cycle.
- Latency:
  - 4th data byte accepted in cycle N → mem_we high in cycle N+1.
  - With mem_ready already high, the handshake completes in N+1 and rx_ready is high again in N+2.
- mem_we is never deasserted before mem_ready, regardless of frame_abort.
- frame_abort:
  - In ADDR or DATA: return to IDLE next cycle, discard the partial frame, leave addr_reg untouched.
  - In IDLE or WRITE: ignored.
  - If it coincides with an accepted byte, abort wins and the byte is dropped.
- Back-to-back frames: an opcode byte presented the cycle after returning to IDLE is accepted with no bubble.
- busy = (state != IDLE).
- mem_addr reflects addr_reg at all times; only mem_we qualifies it.

Test Plan:
1. Address frame then data frame:
   - Stimulus: 01 10 00 00 00, 02 DE AD BE EF, mem_ready tied high.
   - Expect: one write addr 0x1000_0000, data 0xDEADBEEF; wr_count = 1; addr_reg = 0x1000_0004.
2. Auto-increment with memory backpressure:
   - Stimulus: address frame to 0x1000_4000, then 3 data frames; mem_ready low for 5 cycles on each write.
   - Expect: writes at 0x1000_4000, 4004, 4008; mem_we and data stable throughout each stall; rx_ready low while in WRITE.
3. Range and alignment errors:
   - Stimulus: address 0x1000_8000 then data frame; address 0x0FFF_FFFC then data frame; address 0x1000_0002 then data frame.
   - Expect: no mem_we in any case, err_range pulses 3×, wr_count unchanged.
4. Unknown opcode:
   - Stimulus: byte 0x55 in IDLE.
   - Expect: err_opcode pulses once; state stays IDLE; a following 01 frame is parsed normally.
5. Abort mid-frame:
   - Stimulus: 01 20 00 then frame_abort; next 02 11 22 then frame_abort coincident with a byte.
   - Expect: addr_reg keeps its prior value; no write issued; busy drops the cycle after each abort.
6. Reset mid-write:
   - Stimulus: reset asserted while mem_we = 1 with mem_ready low.
   - Expect: next cycle mem_we = 0, wr_count = 0, addr_reg = 0x1000_0000, rx_ready = 1.
